// File: rtl/wb_line_fetcher.sv
// Wishbone classic master that moves one cache line as BEATS single-word transfers.
// Define WB_TIMEOUT_EN to abort a burst with resp_err_o when the slave stops acking.
module wb_line_fetcher #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int LINE_BYTES     = 64,
  parameter int WB_ADDR_WIDTH  = 25,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ADDR_WIDTH-1:0]        req_addr_i,
  input  logic                         req_we_i,
  input  logic [LINE_BYTES*8-1:0]      req_data_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [LINE_BYTES*8-1:0]      resp_data_o,
  output logic                         resp_err_o,
  output logic [WB_ADDR_WIDTH-1:0]     wb_adr_o,
  output logic [DATA_WIDTH-1:0]        wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]      wb_sel_o,
  output logic                         wb_we_o,
  output logic                         wb_cyc_o,
  output logic                         wb_stb_o,
  input  logic                         wb_ack_i,
  input  logic [DATA_WIDTH-1:0]        wb_dat_i
);

  // state | meaning
  // IDLE  | waiting for a line request, req_ready_o high
  // BUS   | cyc/stb held, one beat completes per ack
  // RESP  | line (or error) presented until resp_ready_i

  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int BEATS     = LINE_BITS / DATA_WIDTH;
  localparam int WLSB      = $clog2(DATA_WIDTH / 8);
  localparam int OFF       = $clog2(LINE_BYTES);
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t               state;
  logic [BW-1:0]        beat;
  logic [BW-1:0]        beat_next;
  logic [LINE_BITS-1:0] wdata;
  logic [LINE_BITS-1:0] rbuf;
  logic [LINE_BITS-1:0] rbuf_next;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                 unused_addr_bits;

  assign line_addr        = {req_addr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
  assign word_addr        = line_addr >> WLSB;
  assign unused_addr_bits = ^{req_addr_i[OFF-1:0], word_addr[ADDR_WIDTH-1:WB_ADDR_WIDTH]};
  assign beat_next        = beat + 1'b1;
  assign req_ready_o      = (state == IDLE) & rst_ni;

  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[int'(beat)*DATA_WIDTH +: DATA_WIDTH] = wb_dat_i;
  end

`ifdef WB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmr;
`else
  assign resp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      beat         <= '0;
      wdata        <= '0;
      rbuf         <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
`ifdef WB_TIMEOUT_EN
      resp_err_o   <= 1'b0;
      tmr          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            wdata    <= req_data_i;
            rbuf     <= '0;
            beat     <= '0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= req_we_i;
            wb_sel_o <= '1;
            wb_adr_o <= word_addr[WB_ADDR_WIDTH-1:0];
            wb_dat_o <= req_data_i[DATA_WIDTH-1:0];
            state    <= BUS;
`ifdef WB_TIMEOUT_EN
            resp_err_o <= 1'b0;
            tmr        <= TMR_LOAD;
`endif
          end
        end
        BUS: begin
          if (wb_ack_i) begin
            if (!wb_we_o) rbuf <= rbuf_next;
`ifdef WB_TIMEOUT_EN
            tmr <= TMR_LOAD;
`endif
            if (beat == LAST_BEAT) begin
              wb_cyc_o     <= 1'b0;
              wb_stb_o     <= 1'b0;
              wb_we_o      <= 1'b0;
              wb_adr_o     <= '0;
              wb_dat_o     <= '0;
              wb_sel_o     <= '0;
              resp_valid_o <= 1'b1;
              resp_data_o  <= wb_we_o ? '0 : rbuf_next;
              state        <= RESP;
            end else begin
              // Address advances with the beat so stb never gaps between words.
              beat     <= beat_next;
              wb_adr_o <= wb_adr_o + WB_ADDR_WIDTH'(1);
              wb_dat_o <= wdata[int'(beat_next)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
`ifdef WB_TIMEOUT_EN
          else if (tmr == '0) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            resp_valid_o <= 1'b1;
            resp_data_o  <= '0;
            resp_err_o   <= 1'b1;
            state        <= RESP;
          end else begin
            tmr <= tmr - 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_line_fetcher.sv
// Scoreboard bench for wb_line_fetcher against a RAM-like Wishbone slave model
// that acks every other cycle with combinational read data.
module tb_wb_line_fetcher;
  localparam int LBITS = 512;

  typedef struct {
    logic [24:0] adr;
    logic        we;
    logic [63:0] dat;
  } beat_t;

  typedef struct {
    logic [LBITS-1:0] data;
    logic             err;
  } resp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req_valid, req_ready, req_we;
  logic [31:0]      req_addr;
  logic [LBITS-1:0] req_data;
  logic             resp_valid, resp_ready, resp_err;
  logic [LBITS-1:0] resp_data;
  logic [24:0]      wb_adr;
  logic [63:0]      wb_dat_o, wb_dat_i;
  logic [7:0]       wb_sel;
  logic             wb_we, wb_cyc, wb_stb, ack, mute;
  logic [63:0]      mem [0:255];

  int checks = 0;
  int failures = 0;
  beat_t bus_q[$];
  resp_t resp_q[$];

  always #5 clk = ~clk;

  wb_line_fetcher #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_data_i(req_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_err_o(resp_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(ack), .wb_dat_i(wb_dat_i)
  );

  // RAM slave: registered ack one cycle after cyc&stb, then a gap cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack <= 1'b0;
    else        ack <= wb_cyc & wb_stb & ~ack & ~mute;
  end
  always @(posedge clk) begin
    if (rst_n && ack && wb_cyc && wb_stb && wb_we) mem[wb_adr[7:0]] <= wb_dat_o;
  end
  assign wb_dat_i = mem[wb_adr[7:0]];

  task automatic check(input string name, input logic [LBITS-1:0] act, input logic [LBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LBITS-1:0] mk_line(input logic [63:0] hi, input logic [63:0] base);
    logic [LBITS-1:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = hi | (base + 64'(k));
    return l;
  endfunction

  // Bus monitor: a beat completes at the posedge following a negedge with cyc&stb&ack.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && wb_cyc && wb_stb && ack) begin
      if (bus_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_unexpected: beat at adr %0h with none expected", wb_adr);
      end else begin
        e = bus_q.pop_front();
        check("bus_adr", LBITS'(wb_adr), LBITS'(e.adr));
        check("bus_we", LBITS'(wb_we), LBITS'(e.we));
        check("bus_sel", LBITS'(wb_sel), LBITS'(8'hFF));
        if (e.we) check("bus_dat", LBITS'(wb_dat_o), LBITS'(e.dat));
      end
    end
  end

  // Response monitor: pops on each valid&ready handshake.
  always @(negedge clk) begin
    resp_t r;
    if (rst_n && resp_valid && resp_ready) begin
      if (resp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: response %0h with none expected", resp_data);
      end else begin
        r = resp_q.pop_front();
        check("resp_data", resp_data, r.data);
        check("resp_err", LBITS'(resp_err), LBITS'(r.err));
      end
    end
  end

  task automatic expect_line(input logic [24:0] base, input logic we, input logic [LBITS-1:0] wline,
                             input logic [LBITS-1:0] rline, input bit with_resp);
    for (int k = 0; k < 8; k++) bus_q.push_back('{adr: base + 25'(k), we: we, dat: wline[k*64 +: 64]});
    if (with_resp) resp_q.push_back('{data: rline, err: 1'b0});
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [LBITS-1:0] data);
    int n;
    req_addr  = addr;
    req_we    = we;
    req_data  = data;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    check("req_accept", LBITS'(req_ready), LBITS'(1'b1));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int seen;
    logic [LBITS-1:0] line1, line2;
    line1 = mk_line(64'hA5A5_0000_0000_0000, 64'h0);
    line2 = mk_line(64'h0, 64'h1000);
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    for (int k = 0; k < 8; k++) mem[8 + k] = 64'hA5A5_0000_0000_0000 | 64'(k);
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
    resp_ready = 1'b1; mute = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_cyc", LBITS'(wb_cyc), '0);
    check("rst_stb", LBITS'(wb_stb), '0);
    check("rst_adr", LBITS'(wb_adr), '0);
    check("rst_resp_valid", LBITS'(resp_valid), '0);
    check("rst_resp_data", resp_data, '0);
    check("rst_req_ready", LBITS'(req_ready), '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("post_rst_req_ready", LBITS'(req_ready), LBITS'(1'b1));

    // Line read at 0x80000040: words 0x08..0x0F.
    expect_line(25'h08, 1'b0, '0, line1, 1'b1);
    issue(32'h8000_0040, 1'b0, '0);
    wait_resp(n);
    check("read1_latency", LBITS'(n), LBITS'(16));
    drain();

    // Full-line writeback to 0x80000080, then read it back.
    expect_line(25'h10, 1'b1, line2, '0, 1'b1);
    issue(32'h8000_0080, 1'b1, line2);
    wait_resp(n);
    check("write_latency", LBITS'(n), LBITS'(16));
    drain();
    expect_line(25'h10, 1'b0, '0, line2, 1'b1);
    issue(32'h8000_0080, 1'b0, '0);
    wait_resp(n);
    check("readback_latency", LBITS'(n), LBITS'(16));
    drain();

    // Unaligned address is truncated to the line base.
    expect_line(25'h08, 1'b0, '0, line1, 1'b1);
    issue(32'h8000_007C, 1'b0, '0);
    wait_resp(n);
    check("unaligned_latency", LBITS'(n), LBITS'(16));
    drain();

    // Response back-pressure with a new request already pending.
    resp_ready = 1'b0;
    expect_line(25'h08, 1'b0, '0, line1, 1'b1);
    issue(32'h8000_0040, 1'b0, '0);
    wait_resp(n);
    check("stall_latency", LBITS'(n), LBITS'(16));
    expect_line(25'h10, 1'b0, '0, line2, 1'b1);
    req_addr = 32'h8000_0080; req_we = 1'b0; req_data = '0; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_valid", LBITS'(resp_valid), LBITS'(1'b1));
      check("stall_data", resp_data, line1);
      check("stall_req_ready", LBITS'(req_ready), '0);
      check("stall_cyc", LBITS'(wb_cyc), '0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_req_ready", LBITS'(req_ready), LBITS'(1'b1));
    check("hs_resp_valid", LBITS'(resp_valid), '0);
    check("hs_no_same_cycle_accept", LBITS'(wb_cyc), '0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("pending_accepted", LBITS'(wb_cyc), LBITS'(1'b1));
    wait_resp(n);
    check("pending_latency", LBITS'(n), LBITS'(16));
    drain();

    // Reset during beat 3 of a read: bus released at once, no response.
    expect_line(25'h08, 1'b0, '0, '0, 1'b0);
    issue(32'h8000_0040, 1'b0, '0);
    n = 0;
    while (wb_adr != 25'h0B && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("reach_beat3", LBITS'(wb_adr), LBITS'(25'h0B));
    #1 rst_n = 1'b0;
    #1;
    check("abort_cyc", LBITS'(wb_cyc), '0);
    check("abort_stb", LBITS'(wb_stb), '0);
    check("abort_resp_valid", LBITS'(resp_valid), '0);
    check("abort_req_ready", LBITS'(req_ready), '0);
    check("abort_beats_left", LBITS'(bus_q.size()), LBITS'(5));
    bus_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("abort_release_ready", LBITS'(req_ready), LBITS'(1'b1));
    check("abort_release_cyc", LBITS'(wb_cyc), '0);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1 if (resp_valid || wb_cyc) seen++;
    end
    check("abort_quiet", LBITS'(seen), '0);

`ifdef WB_TIMEOUT_EN
    // Silent slave: burst aborted after 16 BUS cycles with an error response.
    mute = 1'b1;
    resp_q.push_back('{data: '0, err: 1'b1});
    issue(32'h8000_0040, 1'b0, '0);
    wait_resp(n);
    check("timeout_latency", LBITS'(n), LBITS'(16));
    check("timeout_cyc", LBITS'(wb_cyc), '0);
    drain();
    mute = 1'b0;
`endif

    n = 0;
    while ((resp_q.size() != 0 || bus_q.size() != 0) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check("resp_q_drained", LBITS'(resp_q.size()), '0);
    check("bus_q_drained", LBITS'(bus_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
